seq_multiplier_unit: RTL and testbench
======================================

// Module: seq_multiplier_unit
// PURPOSE
//  Parametrised sequential shift-add multiplier with a register-style bus port.
//  Computes one n x n product in n+2 clocks, in unsigned or two's-complement mode.
//  Sits behind the debounce block, on the same func/oe bus as the earlier multiplier.
//  Adds start/ready handshake, a done pulse, signed mode and a status register.
// PARAMETERS
//  n        8   operand width in bits (>= 2); product is 2n bits
//  SIGNED0  0   reset value of the control register signed-mode bit
// PORTS
//  clk      in   1    system clock; all state updates on rising edge
//  nreset   in   1    asynchronous, active-low reset
//  start    in   1    level, already debounced; rising edge starts an operation
//  func     in   3    bus register select (codes below)
//  we       in   1    write strobe for func-selected register, sampled on clk
//  oe       in   1    read enable; dout is driven only while oe=1
//  din      in   n    write data
//  dout     out  n    read data; 'z when oe=0
//  ready    out  1    1 = idle, operands writable, start accepted
//  done     out  1    one-clock pulse when the product is valid
// BEHAVIOUR
//  func: 000 M (multiplicand), 001 Q (multiplier), 010 P[n-1:0] (read only),
//   011 P[2n-1:n] (read only), 100 CTRL (bit0 = signed; read/write),
//   101 STATUS (read only: {.., err, busy, ready}); 11x reads 0, writes ignored.
//  Reset: state IDLE; M, Q, P, accumulator and counter 0; CTRL.signed = SIGNED0;
//   err 0; ready 1; done 0; dout 'z.
//  start edge: registered start_q; go = start & ~start_q. Holding start high
//   gives exactly one operation.
//  FSM: IDLE -> LOAD on go (ready=1 only in IDLE).
//   LOAD: A <= 0, Qs <= Q, Ms <= M, mode latched, cnt <= n-1; -> CALC.
//   CALC, n cycles: if Qs[0], sum = A + Ms (n+1-bit, sign- or zero-extended
//    per mode); on the final step (cnt==0) in signed mode, use A - Ms instead.
//    {A,Qs} <= {sum,Qs} >> 1, arithmetic shift in signed mode, logical otherwise.
//    cnt decrements; -> DONE after the cycle with cnt==0.
//   DONE: P <= {A[n-1:0],Qs}; done=1 for this cycle; -> IDLE.
//  Latency: go seen in cycle k -> done=1 in cycle k+n+2; P readable from k+n+3.
//  P holds its last value until the next DONE; a new operation never clears it.
//  Writes to M, Q or CTRL while ready=0 are ignored and set sticky err.
//   Writing STATUS with din[2]=1 clears err (any state).
//  go while busy: ignored; it does not set err and is not queued.
//  nreset low mid-operation: immediate return to reset state; the operation
//   is lost and no done pulse is produced.
//  Reads are combinational from registers. Reading P during CALC returns the
//   previous product.
// STRUCTURE
//  Package seq_mul_pkg: state_t enum {IDLE, LOAD, CALC, DONE}; func_t localparams
//   FN_M, FN_Q, FN_PLO, FN_PHI, FN_CTRL, FN_STAT; STAT bit index constants.
//  Sub-module seq_mul_datapath #(n): A/Qs/Ms registers, add/sub, shift, sign
//   extension. Controlled by load, step, last and signed_mode.
//  Top level holds the FSM, counter, bus decode, CTRL/STATUS and the tristate.
// TESTING
//  1 n=8 unsigned: M=200, Q=150, start -> done at +10 clk, P=0x7530, ready back.
//  2 signed: M=0xFD (-3), Q=0x05 -> P=0xFFF1. M=0x80, Q=0x80 -> P=0x4000.
//  3 start held high 50 clk -> exactly one done pulse. Second edge during CALC
//    -> no effect, err=0.
//  4 write M=0x11 during CALC -> err=1, result uses old M. STATUS write din=0x04
//    -> err=0.
//  5 nreset low at CALC step 3 -> ready=1, P=0, no done. New op gives correct P.
//  6 n=16 unsigned 0xFFFF*0xFFFF -> P=0xFFFE0001, done at +18 clk.
//    oe=0 -> dout is 'z.

Source files
------------

// File: rtl/seq_mul_pkg.sv
// Shared types and bus codes for the sequential shift-add multiplier.
package seq_mul_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;

  localparam logic [2:0] FN_M    = 3'd0;
  localparam logic [2:0] FN_Q    = 3'd1;
  localparam logic [2:0] FN_PLO  = 3'd2;
  localparam logic [2:0] FN_PHI  = 3'd3;
  localparam logic [2:0] FN_CTRL = 3'd4;
  localparam logic [2:0] FN_STAT = 3'd5;

  localparam int STAT_READY = 0;
  localparam int STAT_BUSY  = 1;
  localparam int STAT_ERR   = 2;

endpackage

// File: rtl/seq_mul_datapath.sv
// Accumulator/multiplier shift register pair: one add (or final subtract) and
// right shift per step, producing the 2n-bit product in {A,Qs}.
module seq_mul_datapath #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         i_load,
  input  logic         i_step,
  input  logic         i_last,
  input  logic         i_signed,
  input  logic [n-1:0] i_m,
  input  logic [n-1:0] i_q,
  output logic [n-1:0] o_a,
  output logic [n-1:0] o_qs
);

  logic [n-1:0] r_a, r_qs, r_ms;
  logic [n:0]   w_a_ext, w_m_ext, w_sum;

  assign w_a_ext = i_signed ? {r_a[n-1], r_a}   : {1'b0, r_a};
  assign w_m_ext = i_signed ? {r_ms[n-1], r_ms} : {1'b0, r_ms};

  // The multiplier's top bit has negative weight in two's complement,
  // so its partial product is subtracted on the final step.
  always_comb begin
    w_sum = w_a_ext;
    if (r_qs[0])
      w_sum = (i_last && i_signed) ? w_a_ext - w_m_ext : w_a_ext + w_m_ext;
  end

  // The n+1-bit sum already carries the sign/carry, so dropping the shifted-out
  // top bit makes arithmetic and logical shift coincide.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_a  <= '0;
      r_qs <= '0;
      r_ms <= '0;
    end else if (i_load) begin
      r_a  <= '0;
      r_qs <= i_q;
      r_ms <= i_m;
    end else if (i_step) begin
      r_a  <= w_sum[n:1];
      r_qs <= {w_sum[0], r_qs[n-1:1]};
    end
  end

  assign o_a  = r_a;
  assign o_qs = r_qs;

endmodule

// File: rtl/seq_multiplier_unit.sv
// Sequential multiplier with start/ready handshake, done pulse and a small
// func-addressed register bus (M, Q, P, CTRL, STATUS) with tristate read port.
module seq_multiplier_unit
  import seq_mul_pkg::*;
#(
  parameter int n       = 8,
  parameter bit SIGNED0 = 1'b0
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         start,
  input  logic [2:0]   func,
  input  logic         we,
  input  logic         oe,
  input  logic [n-1:0] din,
  output logic [n-1:0] dout,
  output logic         ready,
  output logic         done
);

  localparam int CW = $clog2(n);

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [n-1:0]    r_m, r_q;
  logic [2*n-1:0]  r_p;
  logic            r_signed, r_mode, r_err, r_start_q;

  logic            w_go, w_last;
  logic [n-1:0]    w_a, w_qs, w_rd;
  logic [2:0]      w_stat, w_din_lo;

  assign w_go     = start & ~r_start_q;
  assign w_last   = (r_cnt == '0);
  assign w_din_lo = 3'(din);

  seq_mul_datapath #(.n(n)) u_dp (
    .clk      (clk),
    .nreset   (nreset),
    .i_load   (r_state == LOAD),
    .i_step   (r_state == CALC),
    .i_last   (w_last),
    .i_signed (r_mode),
    .i_m      (r_m),
    .i_q      (r_q),
    .o_a      (w_a),
    .o_qs     (w_qs)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_mode    <= 1'b0;
      r_p       <= '0;
      r_start_q <= 1'b0;
      ready     <= 1'b1;
      done      <= 1'b0;
    end else begin
      r_start_q <= start;
      done      <= 1'b0;
      case (r_state)
        IDLE: if (w_go) begin
          r_state <= LOAD;
          ready   <= 1'b0;
        end
        LOAD: begin
          r_mode  <= r_signed;
          r_cnt   <= CW'(n-1);
          r_state <= CALC;
        end
        CALC: begin
          r_cnt <= r_cnt - 1'b1;
          if (w_last) begin
            r_state <= DONE;
            done    <= 1'b1;
          end
        end
        DONE: begin
          r_p     <= {w_a, w_qs};
          r_state <= IDLE;
          ready   <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Operand/CTRL writes are only legal while idle; anything else flags err.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_m      <= '0;
      r_q      <= '0;
      r_signed <= SIGNED0;
      r_err    <= 1'b0;
    end else if (we) begin
      case (func)
        FN_M:    if (ready) r_m <= din;         else r_err <= 1'b1;
        FN_Q:    if (ready) r_q <= din;         else r_err <= 1'b1;
        FN_CTRL: if (ready) r_signed <= din[0]; else r_err <= 1'b1;
        FN_STAT: if (w_din_lo[STAT_ERR]) r_err <= 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_stat             = '0;
    w_stat[STAT_READY] = ready;
    w_stat[STAT_BUSY]  = ~ready;
    w_stat[STAT_ERR]   = r_err;
  end

  always_comb begin
    w_rd = '0;
    case (func)
      FN_M:    w_rd = r_m;
      FN_Q:    w_rd = r_q;
      FN_PLO:  w_rd = r_p[n-1:0];
      FN_PHI:  w_rd = r_p[2*n-1:n];
      FN_CTRL: w_rd = n'(r_signed);
      FN_STAT: w_rd = n'(w_stat);
      default: w_rd = '0;
    endcase
  end

  assign dout = oe ? w_rd : 'z;

endmodule

// File: tb/tb_seq_multiplier_unit.sv
// Scoreboard bench: expected products queued at launch, compared when done fires.
module tb_seq_multiplier_unit;
  import seq_mul_pkg::*;

  logic clk = 1'b0;
  logic nreset;
  always #5 clk = ~clk;

  logic       start, we, oe;
  logic [2:0] func;
  logic [7:0] din;
  wire  [7:0] dout;
  logic       ready, done;

  logic        start16, we16, oe16;
  logic [2:0]  func16;
  logic [15:0] din16;
  wire  [15:0] dout16;
  logic        ready16, done16;

  seq_multiplier_unit #(.n(8), .SIGNED0(1'b0)) dut (
    .clk(clk), .nreset(nreset), .start(start), .func(func), .we(we), .oe(oe),
    .din(din), .dout(dout), .ready(ready), .done(done)
  );

  seq_multiplier_unit #(.n(16), .SIGNED0(1'b0)) dut16 (
    .clk(clk), .nreset(nreset), .start(start16), .func(func16), .we(we16), .oe(oe16),
    .din(din16), .dout(dout16), .ready(ready16), .done(done16)
  );

  int n_chk = 0, n_err = 0, n_done = 0;
  logic [31:0] sb[$];
  logic [7:0]  zz8 = 'z;
  logic [15:0] zz16 = 'z;

  always @(negedge clk) if (done) n_done++;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic wr(input logic [2:0] f, input logic [7:0] d);
    @(negedge clk); func = f; din = d; we = 1'b1;
    @(negedge clk); we = 1'b0;
  endtask

  task automatic rd(input logic [2:0] f, output logic [7:0] d);
    @(negedge clk); func = f; oe = 1'b1;
    #1 d = dout;
    oe = 1'b0;
  endtask

  task automatic setup(input logic [7:0] m, input logic [7:0] q, input logic s);
    wr(FN_CTRL, {7'b0, s});
    wr(FN_M, m);
    wr(FN_Q, q);
  endtask

  // Caller raises start on the preceding negedge.
  task automatic wait_done(input int lat);
    int cyc = 0;
    logic [7:0] lo, hi;
    logic [31:0] e;
    while (cyc < 40) begin
      @(posedge clk); cyc++;
      #1; if (done) break;
    end
    chk("latency", cyc, lat);
    @(posedge clk); #1;
    chk("ready_after", {31'b0, ready}, 32'd1);
    rd(FN_PLO, lo);
    rd(FN_PHI, hi);
    e = (sb.size() > 0) ? sb.pop_front() : 32'hxxxx_xxxx;
    chk("product", {16'b0, hi, lo}, e);
  endtask

  task automatic mul(input logic [7:0] m, input logic [7:0] q, input logic s,
                     input logic [15:0] exp);
    setup(m, q, s);
    sb.push_back({16'b0, exp});
    @(negedge clk); start = 1'b1;
    fork
      wait_done(10);
      begin @(negedge clk); start = 1'b0; end
    join
  endtask

  initial begin
    logic [7:0]  r;
    logic [15:0] lo16, hi16;
    int d0, cyc;

    nreset = 1'b0; start = 0; we = 0; oe = 0; func = '0; din = '0;
    start16 = 0; we16 = 0; oe16 = 0; func16 = '0; din16 = '0;
    repeat (3) @(negedge clk);
    nreset = 1'b1;

    // reset state
    #1;
    chk("rst_ready", {31'b0, ready}, 32'd1);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_dout_z", {24'b0, dout}, {24'b0, zz8});
    rd(FN_STAT, r); chk("rst_stat", {24'b0, r}, 32'h01);
    rd(FN_PLO, r);  chk("rst_plo", {24'b0, r}, 32'h00);
    rd(FN_CTRL, r); chk("rst_ctrl", {24'b0, r}, 32'h00);
    rd(3'b110, r);  chk("rd_unused", {24'b0, r}, 32'h00);

    // n=16 unsigned max operands
    @(negedge clk); func16 = FN_M; din16 = 16'hFFFF; we16 = 1'b1;
    @(negedge clk); func16 = FN_Q;
    @(negedge clk); we16 = 1'b0;
    sb.push_back(32'hFFFE_0001);
    start16 = 1'b1;
    cyc = 0;
    while (cyc < 60) begin
      @(posedge clk); cyc++;
      #1; if (done16) break;
    end
    chk("latency16", cyc, 18);
    @(negedge clk); start16 = 1'b0;
    @(negedge clk); func16 = FN_PLO; oe16 = 1'b1;
    #1 lo16 = dout16;
    func16 = FN_PHI;
    #1 hi16 = dout16;
    oe16 = 1'b0;
    #1 chk("dout16_z", {16'b0, dout16}, {16'b0, zz16});
    chk("product16", {hi16, lo16}, sb.pop_front());

    // unsigned and signed products
    mul(8'd200, 8'd150, 1'b0, 16'h7530);
    mul(8'hFF,  8'hFF,  1'b0, 16'hFE01);
    mul(8'hFD,  8'h05,  1'b1, 16'hFFF1);
    mul(8'h80,  8'h80,  1'b1, 16'h4000);
    mul(8'h7F,  8'h81,  1'b1, 16'hC0FF);

    // start held high: exactly one operation
    setup(8'd13, 8'd17, 1'b0);
    sb.push_back(32'd221);
    d0 = n_done;
    @(negedge clk); start = 1'b1;
    fork
      wait_done(10);
      begin repeat (50) @(negedge clk); start = 1'b0; end
    join
    chk("held_one_done", n_done - d0, 1);

    // second edge during CALC is ignored and does not set err
    setup(8'd9, 8'd9, 1'b0);
    sb.push_back(32'd81);
    d0 = n_done;
    @(negedge clk); start = 1'b1;
    fork
      wait_done(10);
      begin
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
      end
    join
    repeat (15) @(negedge clk);
    chk("poke_one_done", n_done - d0, 1);
    rd(FN_STAT, r); chk("poke_no_err", {24'b0, r}, 32'h01);

    // write while busy: err set, old M used, STATUS write clears err
    setup(8'd7, 8'd9, 1'b0);
    sb.push_back(32'd63);
    @(negedge clk); start = 1'b1;
    fork
      wait_done(10);
      begin
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        wr(FN_M, 8'h11);
      end
    join
    rd(FN_STAT, r); chk("busy_wr_err", {24'b0, r}, 32'h05);
    rd(FN_M, r);    chk("busy_wr_m_kept", {24'b0, r}, 32'h07);
    wr(FN_STAT, 8'h04);
    rd(FN_STAT, r); chk("err_clear", {24'b0, r}, 32'h01);

    // reset mid-calculation: op lost, no done pulse, P cleared
    setup(8'd12, 8'd11, 1'b0);
    d0 = n_done;
    @(negedge clk); start = 1'b1;
    repeat (4) @(posedge clk);
    #2 nreset = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    #1 chk("rst_mid_ready", {31'b0, ready}, 32'd1);
    repeat (20) @(negedge clk);
    chk("rst_mid_no_done", n_done - d0, 0);
    rd(FN_PLO, r); chk("rst_mid_plo", {24'b0, r}, 32'h00);
    rd(FN_PHI, r); chk("rst_mid_phi", {24'b0, r}, 32'h00);
    mul(8'd12, 8'd11, 1'b0, 16'd132);

    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
